// File: rtl/pinwheel_regfile_ctrl.sv
// Clear-sweep, write-port arbitration and x0 protection in front of the threaded register file.
// Optional read-during-write bypass is enabled by defining PINWHEEL_REGFILE_BYPASS_EN.
module pinwheel_regfile_ctrl #(
    parameter int unsigned reg_count    = 32,
    parameter int unsigned reg_width    = 32,
    parameter int unsigned thread_count = 4,
    localparam int unsigned reg_total   = reg_count * thread_count,
    localparam int unsigned addr_bits   = $clog2(reg_total),
    localparam int unsigned idx_bits    = $clog2(reg_count)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 busy,
    input  logic                 core_rden,
    input  logic [addr_bits-1:0] core_raddr0,
    input  logic [addr_bits-1:0] core_raddr1,
    output logic [reg_width-1:0] core_rdata0,
    output logic [reg_width-1:0] core_rdata1,
    input  logic                 core_wren,
    input  logic [addr_bits-1:0] core_waddr,
    input  logic [reg_width-1:0] core_wdata,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [addr_bits-1:0] dbg_addr,
    input  logic [reg_width-1:0] dbg_wdata,
    output logic                 dbg_ready,
    output logic                 dbg_rvalid,
    output logic [reg_width-1:0] dbg_rdata,
    output logic [addr_bits-1:0] rf_raddr0,
    output logic [addr_bits-1:0] rf_raddr1,
    input  logic [reg_width-1:0] rf_rdata0,
    input  logic [reg_width-1:0] rf_rdata1,
    output logic [addr_bits-1:0] rf_waddr,
    output logic [reg_width-1:0] rf_wdata,
    output logic                 rf_wren
);

    localparam logic [addr_bits-1:0] last_addr = addr_bits'(reg_total - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state;
    state_t               state_nx;
    logic [addr_bits-1:0] clear_ptr;

    logic                 wr_req;
    logic [addr_bits-1:0] wr_addr;
    logic [reg_width-1:0] wr_data;
    logic                 wr_keep;
    logic                 dbg_rd_go;
    logic                 rd_pend;
    logic [reg_width-1:0] rd0;
    logic [reg_width-1:0] rd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR)
                clear_ptr <= (clear_ptr == last_addr) ? '0 : clear_ptr + addr_bits'(1);
        end
    end

    always_comb begin
        state_nx = state;
        if (state == CLEAR && clear_ptr == last_addr)
            state_nx = RUN;
    end

    always_comb begin
        busy      = 1'b0;
        dbg_ready = 1'b0;
        dbg_rd_go = 1'b0;
        wr_req    = 1'b0;
        wr_addr   = core_waddr;
        wr_data   = core_wdata;
        rf_raddr0 = core_raddr0;
        unique case (state)
            CLEAR: begin
                busy    = 1'b1;
                wr_req  = 1'b1;
                wr_addr = clear_ptr;
                wr_data = '0;
            end
            RUN: begin
                if (core_wren) begin
                    wr_req = 1'b1;
                end else if (dbg_req && dbg_we) begin
                    dbg_ready = 1'b1;
                    wr_req    = 1'b1;
                    wr_addr   = dbg_addr;
                    wr_data   = dbg_wdata;
                end
                // Debug reads borrow port 0 only when the core leaves both read ports idle
                if (dbg_req && !dbg_we && !core_rden) begin
                    dbg_ready = 1'b1;
                    dbg_rd_go = 1'b1;
                    rf_raddr0 = dbg_addr;
                end
            end
            default: ;
        endcase
    end

    // The sweep must zero x0 itself; the x0 filter applies only to run-time writes
    assign wr_keep   = wr_req && (state == CLEAR || wr_addr[idx_bits-1:0] != '0);
    assign rf_wren   = wr_keep;
    assign rf_waddr  = wr_addr;
    assign rf_wdata  = wr_data;
    assign rf_raddr1 = core_raddr1;

`ifdef PINWHEEL_REGFILE_BYPASS_EN
    logic                 byp_wren;
    logic [addr_bits-1:0] byp_waddr;
    logic [reg_width-1:0] byp_wdata;
    logic [addr_bits-1:0] byp_raddr0;
    logic [addr_bits-1:0] byp_raddr1;

    // Port-0 address is the effective one, so stolen debug reads are bypassed too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_wren   <= 1'b0;
            byp_waddr  <= '0;
            byp_wdata  <= '0;
            byp_raddr0 <= '0;
            byp_raddr1 <= '0;
        end else begin
            byp_wren   <= wr_keep;
            byp_waddr  <= wr_addr;
            byp_wdata  <= wr_data;
            byp_raddr0 <= rf_raddr0;
            byp_raddr1 <= core_raddr1;
        end
    end

    assign rd0 = (byp_wren && byp_raddr0 == byp_waddr) ? byp_wdata : rf_rdata0;
    assign rd1 = (byp_wren && byp_raddr1 == byp_waddr) ? byp_wdata : rf_rdata1;
`else
    assign rd0 = rf_rdata0;
    assign rd1 = rf_rdata1;
`endif

    assign core_rdata0 = rd0;
    assign core_rdata1 = rd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            rd_pend    <= dbg_rd_go;
            dbg_rvalid <= rd_pend;
            if (rd_pend)
                dbg_rdata <= rd0;
        end
    end

endmodule
